// File: rtl/hilo_mul_controller_pkg.sv
// Shared encodings for the multu/mfhi/mflo controller and the instruction decoder.
package hilo_mul_controller_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    // alucontrol codes the decoder emits for the HI/LO instructions
    localparam logic [2:0] ALU_MULTU = 3'b011;
    localparam logic [2:0] ALU_MFHI  = 3'b100;
    localparam logic [2:0] ALU_MFLO  = 3'b101;

endpackage

// File: rtl/hilo_mul_controller_shift_add_step.sv
// One shift-add multiply iteration: conditional add into the upper half of P, then logical shift right.
module shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] p_in,
    input  logic [WIDTH-1:0] mcand,
    output logic [2*WIDTH:0] p_out
);

    logic [WIDTH:0] upper;

    // Upper field is WIDTH+1 bits so the carry out of the add survives the shift.
    always_comb begin
        upper = p_in[2*WIDTH:WIDTH];
        if (p_in[0]) begin
            upper = p_in[2*WIDTH:WIDTH] + {1'b0, mcand};
        end
        p_out = {1'b0, upper, p_in[WIDTH-1:1]};
    end

endmodule

// File: rtl/hilo_mul_controller.sv
// Sequencer for multu (32-step shift-add) owning HI/LO, with core stall for dependent HI/LO accesses.
module hilo_mul_controller
    import hilo_mul_controller_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             rd_hi,
    input  logic             rd_lo,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH:0] p;
    logic [2*WIDTH:0] p_step;
    logic [CW-1:0]    count;

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .p_in  (p),
        .mcand (mcand),
        .p_out (p_step)
    );

    assign stall = (start | rd_hi | rd_lo) & (state != IDLE);
    assign rdata = rd_hi ? hi : lo;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (count == CW'(WIDTH - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            mcand <= '0;
            p     <= '0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= srca;
                        p     <= {{(WIDTH + 1){1'b0}}, srcb};
                        count <= '0;
                    end
                end
                RUN: begin
                    p     <= p_step;
                    count <= count + 1'b1;
                end
                COMMIT: begin
                    hi <= p[2*WIDTH-1:WIDTH];
                    lo <= p[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule
